// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared defaults and types for the shared adder arbiter
// Purpose: default geometry of the shared add/sub datapath, the round-robin
//          pointer reset value and the response-register state encoding.
// Ports:   none (package).
package adder_share_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int WIDTH_DEF   = 32;
   localparam int ID_W_DEF    = 2;

   // Round-robin search starts at requester 0 after reset.
   localparam int RR_PTR_RST  = 0;

   // Response register occupancy; FULL is exactly "rsp_valid is high".
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/rr_grant_picker.sv
// rtl/rr_grant_picker.sv - combinational round-robin picker
// Purpose: picks the first asserted request at or above ptr, wrapping at
//          NUM_REQ, and reports it as a one-hot grant and a binary index.
// Ports:   req       in  NUM_REQ  request vector
//          ptr       in  ID_W     search start position (must be < NUM_REQ)
//          grant     out NUM_REQ  one-hot grant, zero when nothing requests
//          idx       out ID_W     index of the granted request
//          any_valid out 1        at least one request is asserted
module rr_grant_picker
   import adder_share_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = ID_W_DEF
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any_valid
);

   logic [ID_W:0] cand;

   always_comb begin
      cand      = '0;
      idx       = '0;
      any_valid = 1'b0;
      grant     = '0;
      // Walk ptr, ptr+1, ... with wrap; the first hit wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!any_valid && req[cand[ID_W-1:0]]) begin
            any_valid = 1'b1;
            idx       = cand[ID_W-1:0];
         end
      end
      if (any_valid) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one add/sub datapath shared by round-robin requesters
// Purpose: arbitrates NUM_REQ operand requests onto a single WIDTH-bit
//          adder/subtractor and returns a registered, id-tagged result on one
//          backpressured response channel.
// Ports:   clk, rst                 clock, synchronous active-high reset
//          req_valid/req_ready      per-requester handshake (ready is one-hot)
//          req_a/req_b/req_sub      packed operands and op select, slice i = requester i
//          rsp_valid/rsp_ready      response handshake
//          rsp_id                   owner of the held result
//          rsp_sum/rsp_cout/rsp_ovf result, carry-out (sub: 1 = no borrow), signed overflow
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int ID_W    = ID_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_sub,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_cout,
   output logic                     rsp_ovf,
   input  logic                     rsp_ready
);

   rsp_state_e        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
   logic              rsp_cout_q, rsp_cout_d;
   logic              rsp_ovf_q, rsp_ovf_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    pick_idx;
   logic               any_valid;
   logic               can_issue;
   logic               accept;

   logic [WIDTH-1:0]   a_arr [NUM_REQ];
   logic [WIDTH-1:0]   b_arr [NUM_REQ];
   logic [WIDTH-1:0]   a_sel, b_sel, bx;
   logic               sub_sel;
   logic [WIDTH:0]     add_full;
   logic               ovf;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
   end

   rr_grant_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .idx       (pick_idx),
      .any_valid (any_valid)
   );

   assign rsp_valid = (state_q == ST_FULL);
   assign can_issue = !rsp_valid || rsp_ready;
   // Nothing is offered while reset is held, so no request can slip in.
   assign req_ready = (can_issue && !rst) ? grant : '0;
   assign accept    = any_valid && can_issue && !rst;

   // Shared datapath: subtraction is A + ~B + 1 through the same adder.
   assign a_sel    = a_arr[pick_idx];
   assign b_sel    = b_arr[pick_idx];
   assign sub_sel  = req_sub[pick_idx];
   assign bx       = sub_sel ? ~b_sel : b_sel;
   assign add_full = {1'b0, a_sel} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_sel};
   assign ovf      = (a_sel[WIDTH-1] == bx[WIDTH-1]) && (add_full[WIDTH-1] != a_sel[WIDTH-1]);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_id_d   = rsp_id_q;
      rsp_sum_d  = rsp_sum_q;
      rsp_cout_d = rsp_cout_q;
      rsp_ovf_d  = rsp_ovf_q;

      unique case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (!accept && rsp_ready) state_d = ST_EMPTY;
      endcase

      // A drain and an accept in the same cycle simply overwrite the register.
      if (accept) begin
         rsp_id_d   = pick_idx;
         rsp_sum_d  = add_full[WIDTH-1:0];
         rsp_cout_d = add_full[WIDTH];
         rsp_ovf_d  = ovf;
         rr_ptr_d   = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         rr_ptr_q   <= ID_W'(RR_PTR_RST);
         rsp_id_q   <= '0;
         rsp_sum_q  <= '0;
         rsp_cout_q <= 1'b0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_sum_q  <= rsp_sum_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign rsp_id   = rsp_id_q;
   assign rsp_sum  = rsp_sum_q;
   assign rsp_cout = rsp_cout_q;
   assign rsp_ovf  = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int ID_W    = 2;

   logic                     clk;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_sub;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_cout;
   logic                     rsp_ovf;
   logic                     rsp_ready;

   int checks;
   int failures;

   adder_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf),
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
      req_valid[i]        = 1'b1;
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_sub[i]          = sub;
   endtask

   task automatic check_rsp(input string tag, input logic [1:0] id, input logic [31:0] sum,
                            input logic cout, input logic ovf);
      check({tag, ".valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".id"},    64'(rsp_id),    64'(id));
      check({tag, ".sum"},   64'(rsp_sum),   64'(sum));
      check({tag, ".cout"},  64'(rsp_cout),  64'(cout));
      check({tag, ".ovf"},   64'(rsp_ovf),   64'(ovf));
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[5];

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b1;

      vecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};

      // Reset state, with a request presented during reset.
      tick();
      set_req(0, 32'h1, 32'h1, 1'b0);
      #2;
      check("rst.req_ready", 64'(req_ready), 64'h0);
      tick();
      check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst.rsp_id",    64'(rsp_id),    64'd0);
      check("rst.rsp_sum",   64'(rsp_sum),   64'd0);
      check("rst.rsp_cout",  64'(rsp_cout),  64'd0);
      check("rst.rsp_ovf",   64'(rsp_ovf),   64'd0);

      // 1: single add on requester 0.
      rst = 1'b0;
      set_req(0, 32'h0000_0004, 32'h0000_1000, 1'b0);
      #2;
      check("t1.req_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      check_rsp("t1", 2'd0, 32'h0000_1004, 1'b0, 1'b0);

      // Re-reset so the round-robin sequence starts at 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // 2: all requesters valid, full-rate draining.
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, 32'h100 * (i + 1), 32'(i + 1), 1'b0);
      end
      for (int k = 0; k < 5; k++) begin
         int exp_id;
         exp_id = k % NUM_REQ;
         #2;
         check($sformatf("t2.ready%0d", k), 64'(req_ready), 64'(1 << exp_id));
         tick();
         check_rsp($sformatf("t2.rsp%0d", k), 2'(exp_id), 32'h101 * (exp_id + 1), 1'b0, 1'b0);
      end
      req_valid = '0;
      tick();
      check("t2.drain_valid", 64'(rsp_valid), 64'd0);

      // 3: arithmetic corners through requester 1 (rr_ptr is 1 here).
      for (int v = 0; v < 5; v++) begin
         set_req(1, vecs[v].a, vecs[v].b, vecs[v].sub);
         #2;
         check($sformatf("t3.ready%0d", v), 64'(req_ready), 64'h2);
         tick();
         check_rsp($sformatf("t3.v%0d", v), 2'd1, vecs[v].sum, vecs[v].cout, vecs[v].ovf);
      end
      req_valid = '0;

      // 4: stall for 3 cycles with requester 2 waiting, then release with no bubble.
      rsp_ready = 1'b0;
      set_req(2, 32'h0000_0100, 32'h0000_0023, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #2;
         check($sformatf("t4.stall_ready%0d", k), 64'(req_ready), 64'h0);
         tick();
         check_rsp($sformatf("t4.hold%0d", k), 2'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      end
      rsp_ready = 1'b1;
      #2;
      check("t4.release_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      check_rsp("t4.rsp", 2'd2, 32'h0000_0123, 1'b0, 1'b0);

      // 5: requester 3 at rr_ptr=3, pointer wraps to 0.
      set_req(3, 32'h0000_0001, 32'h0000_0002, 1'b0);
      #2;
      check("t5.ready3", 64'(req_ready), 64'h8);
      tick();
      check_rsp("t5.rsp3", 2'd3, 32'h0000_0003, 1'b0, 1'b0);
      set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
      #2;
      check("t5.ready_wrap", 64'(req_ready), 64'h1);
      tick();
      check_rsp("t5.rsp0", 2'd0, 32'h0000_0030, 1'b0, 1'b0);

      // 6: reset with a held result and requests pending.
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, 32'h0000_0001, 32'h0000_0001, 1'b0);
      end
      rst = 1'b1;
      #2;
      check("t6.ready_in_rst", 64'(req_ready), 64'h0);
      tick();
      check("t6.rsp_valid", 64'(rsp_valid), 64'd0);
      check("t6.rsp_sum",   64'(rsp_sum),   64'd0);
      tick();
      check("t6.no_accept", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      #2;
      check("t6.ptr_zero", 64'(req_ready), 64'h1);
      tick();
      check_rsp("t6.rsp", 2'd0, 32'h0000_0002, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
